// File: rtl/grey_digit_pkg.sv
// Shared definitions for the grey digit receiver: symbol codes, frame states and the
// code-to-BCD lookup used by the decoder.
package grey_digit_pkg;

  localparam logic [4:0] ZERO  = 5'b10001;
  localparam logic [4:0] ONE   = 5'b00001;
  localparam logic [4:0] TWO   = 5'b00011;
  localparam logic [4:0] THREE = 5'b00010;
  localparam logic [4:0] FOUR  = 5'b00110;
  localparam logic [4:0] FIVE  = 5'b00100;
  localparam logic [4:0] SIX   = 5'b01100;
  localparam logic [4:0] SEVEN = 5'b01000;
  localparam logic [4:0] EIGHT = 5'b11000;
  localparam logic [4:0] NINE  = 5'b10000;
  localparam logic [4:0] DP    = 5'b10101;

  typedef enum logic [2:0] {S_HUNT, S_DP, S_D100, S_D010, S_D001} state_t;

  // Result layout is {valid, is_dp, bcd[3:0]}; the DP marker is a valid code but not a digit.
  function automatic logic [5:0] grey2bcd(input logic [4:0] code);
    case (code)
      ZERO:    grey2bcd = 6'b10_0000;
      ONE:     grey2bcd = 6'b10_0001;
      TWO:     grey2bcd = 6'b10_0010;
      THREE:   grey2bcd = 6'b10_0011;
      FOUR:    grey2bcd = 6'b10_0100;
      FIVE:    grey2bcd = 6'b10_0101;
      SIX:     grey2bcd = 6'b10_0110;
      SEVEN:   grey2bcd = 6'b10_0111;
      EIGHT:   grey2bcd = 6'b10_1000;
      NINE:    grey2bcd = 6'b10_1001;
      DP:      grey2bcd = 6'b11_0000;
      default: grey2bcd = 6'b00_0000;
    endcase
  endfunction

endpackage

// File: rtl/grey_digit_decode.sv
// Combinational decode of one synchronised 5-bit grey symbol into validity, DP flag and BCD.
module grey_digit_decode
  import grey_digit_pkg::*;
(
  input  logic [4:0] code,
  output logic       valid,
  output logic       is_dp,
  output logic [3:0] bcd
);

  always_comb begin
    {valid, is_dp, bcd} = grey2bcd(code);
  end

endmodule

// File: rtl/grey_digit_rx.sv
// Frame receiver for the DP/hundreds/tens/units grey stream. Optional macro
// GREY_RX_ERRCNT_EN adds o_err_cnt, a saturating count of o_err pulses.
module grey_digit_rx
  import grey_digit_pkg::*;
#(
  parameter int SYM_CYCLES  = 20001,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_grey,
  output logic [3:0] o_100,
  output logic [3:0] o_010,
  output logic [3:0] o_001,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_err
`ifdef GREY_RX_ERRCNT_EN
  ,
  output logic [7:0] o_err_cnt
`endif
);

  localparam int CW = $clog2(SYM_CYCLES);
  localparam logic [CW-1:0] MID  = CW'(SYM_CYCLES / 2);
  localparam logic [CW-1:0] LAST = CW'(SYM_CYCLES - 1);

  logic [4:0]    sync_q [SYNC_STAGES];
  logic [4:0]    s;
  logic [4:0]    s_prev;
  logic          dp_edge;
  logic          dec_valid;
  logic          dec_dp;
  logic [3:0]    dec_bcd;
  logic          mid_bad;
  logic          realign_ok;
  logic [CW-1:0] cnt;
  state_t        state;
  logic [3:0]    h_q;
  logic [3:0]    t_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= i_grey;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign dp_edge = (s == DP) && (s_prev != DP);

  grey_digit_decode u_decode (
    .code  (s),
    .valid (dec_valid),
    .is_dp (dec_dp),
    .bcd   (dec_bcd)
  );

  // DP slots must hold the marker; digit slots must hold a real digit.
  assign mid_bad    = (state == S_DP) ? !dec_dp : !(dec_valid && !dec_dp);
  // A DP edge is expected during the DP slot or late in the units slot (clock skew).
  assign realign_ok = (state == S_DP) || ((state == S_D001) && (cnt > MID));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_HUNT;
      cnt      <= '0;
      o_100    <= '0;
      o_010    <= '0;
      o_001    <= '0;
      o_valid  <= 1'b0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (state == S_HUNT) begin
        cnt <= '0;
        if (dp_edge) state <= S_DP;
      end else if (dp_edge) begin
        state <= S_DP;
        cnt   <= '0;
        if (!realign_ok) begin
          o_err    <= 1'b1;
          o_locked <= 1'b0;
        end
      end else if ((cnt == MID) && mid_bad) begin
        o_err    <= 1'b1;
        o_locked <= 1'b0;
        state    <= S_HUNT;
        cnt      <= '0;
      end else begin
        if (cnt == MID) begin
          case (state)
            S_D100: h_q <= dec_bcd;
            S_D010: t_q <= dec_bcd;
            S_D001: begin
              o_100    <= h_q;
              o_010    <= t_q;
              o_001    <= dec_bcd;
              o_valid  <= 1'b1;
              o_locked <= 1'b1;
            end
            default: ;
          endcase
        end
        if (cnt == LAST) begin
          cnt <= '0;
          case (state)
            S_DP:    state <= S_D100;
            S_D100:  state <= S_D010;
            S_D010:  state <= S_D001;
            default: state <= S_DP;
          endcase
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef GREY_RX_ERRCNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (o_err && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_grey_digit_rx.sv
// Scoreboard bench for grey_digit_rx: frame-level expectations queued by the stimulus,
// popped and compared by a monitor whenever the receiver reports a frame or an error.
module tb_grey_digit_rx;

  localparam int SYM = 16;
  localparam logic [4:0] DPC = 5'b10101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] grey = 5'b00000;
  logic [3:0] o_100, o_010, o_001;
  logic       o_valid, o_locked, o_err;
`ifdef GREY_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  grey_digit_rx #(.SYM_CYCLES(SYM), .SYNC_STAGES(2)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_grey   (grey),
    .o_100    (o_100),
    .o_010    (o_010),
    .o_001    (o_001),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_err    (o_err)
`ifdef GREY_RX_ERRCNT_EN
    ,
    .o_err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [3:0] h, t, u;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         exp_errs = 0;
  logic [3:0] last_h = 0, last_t = 0, last_u = 0;
  logic [4:0] enc [10] = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                           5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_code(input logic [4:0] c);
    if (c == DPC) return 1'b1;
    for (int i = 0; i < 10; i++) if (enc[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] rand_bad();
    logic [4:0] c;
    do c = 5'($urandom); while (is_code(c));
    return c;
  endfunction

  // Monitor: every receiver event must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_h = 0; last_t = 0; last_u = 0;
    end else if (o_valid || o_err) begin
      if (q.size() == 0) begin
        check("unexpected_event", {30'b0, o_valid, o_err}, 0);
      end else begin
        e = q.pop_front();
        check("event_kind", {30'b0, o_err, o_valid}, e.is_err ? 2 : 1);
        if (e.is_err) begin
          check("locked_after_err", o_locked, 0);
          check("hold_100", o_100, last_h);
          check("hold_010", o_010, last_t);
          check("hold_001", o_001, last_u);
        end else begin
          check("digit_100", o_100, e.h);
          check("digit_010", o_010, e.t);
          check("digit_001", o_001, e.u);
          check("locked_after_frame", o_locked, 1);
          last_h = e.h; last_t = e.t; last_u = e.u;
        end
        if (e.due >= 0) check("frame_latency", cyc, e.due);
      end
    end
  end

  task automatic sym(input logic [4:0] c, input int len);
    grey = c;
    repeat (len) @(negedge clk);
  endtask

  // bad: 0 = good frame, 1..3 = slot carrying badc instead of a digit.
  task automatic frame(input int h, input int t, input int u, input int per,
                       input int bad, input logic [4:0] badc, input bit timed);
    exp_t e;
    e.is_err = (bad != 0);
    e.h = 4'(h); e.t = 4'(t); e.u = 4'(u);
    e.due = timed ? cyc + 60 : -1;
    q.push_back(e);
    if (bad != 0) exp_errs++;
    sym(DPC, per);
    sym((bad == 1) ? badc : enc[h], per);
    sym((bad == 2) ? badc : enc[t], per);
    sym((bad == 3) ? badc : enc[u], per);
  endtask

  // Parking on DP: the following hundreds slot sees DP and must flag an error.
  task automatic finish_stream();
    exp_t e;
    e.is_err = 1'b1; e.h = 0; e.t = 0; e.u = 0; e.due = -1;
    q.push_back(e);
    exp_errs++;
    sym(DPC, 3 * SYM);
    sym(enc[0], 4);
  endtask

  // Short DP-digit bursts put a DP edge inside the hundreds slot each time.
  task automatic bursts(input int n);
    exp_t e;
    e.is_err = 1'b1; e.h = 0; e.t = 0; e.u = 0; e.due = -1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin q.push_back(e); exp_errs++; end
      sym(DPC, 18);
      sym(enc[1], 2);
    end
    q.push_back(e);
    exp_errs++;
    finish_stream();
  endtask

  task automatic check_cnt();
`ifdef GREY_RX_ERRCNT_EN
    check("err_cnt", err_cnt, (exp_errs > 255) ? 255 : exp_errs);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int per, bad;
    rst_n = 1'b0;
    grey = 5'b00000;
    repeat (3) @(negedge clk);
    check("rst_100", o_100, 0);
    check("rst_010", o_010, 0);
    check("rst_001", o_001, 0);
    check("rst_valid", o_valid, 0);
    check("rst_locked", o_locked, 0);
    check("rst_err", o_err, 0);
    check_cnt();
    rst_n = 1'b1;
    @(negedge clk);

    frame(5, 1, 9, SYM, 0, 5'b0, 1'b1);
    finish_stream();
    check_cnt();

    sym(enc[4], SYM / 2);
    sym(enc[8], SYM);
    frame(2, 6, 3, SYM, 0, 5'b0, 1'b0);

    frame(4, 0, 8, SYM, 0, 5'b0, 1'b0);
    frame(1, 2, 3, SYM, 2, 5'b11111, 1'b0);
    frame(6, 6, 1, SYM, 0, 5'b0, 1'b0);
    frame(7, 7, 7, SYM, 0, 5'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      frame($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), 15, 0, 5'b0, 1'b0);
    finish_stream();
    check_cnt();

    for (int i = 0; i < 40; i++) begin
      per = $urandom_range(17, 15);
      bad = ($urandom_range(4, 0) == 0) ? $urandom_range(3, 1) : 0;
      frame($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), per, bad,
            rand_bad(), 1'b0);
    end
    finish_stream();
    check_cnt();

    frame(3, 5, 7, SYM, 0, 5'b0, 1'b0);
    sym(DPC, SYM);
    sym(enc[2], SYM);
    sym(enc[9], 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_100", o_100, 0);
    check("midrst_010", o_010, 0);
    check("midrst_001", o_001, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_locked", o_locked, 0);
    check("midrst_err", o_err, 0);
    check("midrst_queue", q.size(), 0);
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    sym(enc[9], SYM);

    bursts(2);
    check_cnt();
    frame(8, 4, 2, SYM, 0, 5'b0, 1'b0);
    frame(0, 9, 5, 17, 0, 5'b0, 1'b0);
    finish_stream();
`ifdef GREY_RX_ERRCNT_EN
    bursts(300);
    check_cnt();
`endif

    repeat (10) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
